// File: rtl/calc_pkg.sv
// Address-width helpers for the framebuffer port.
package calc_pkg;
   // A single-entry dimension still needs one address bit so the port exists.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int num_row_address_bits(input int pixel_height);
      return clog2_min1(pixel_height);
   endfunction

   function automatic int num_column_address_bits(input int pixel_width);
      return clog2_min1(pixel_width);
   endfunction

   function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
      return clog2_min1(bytes_per_pixel);
   endfunction
endpackage

// File: rtl/cmd_pkg.sv
// State encoding and byte-count helper for the row dump command.
package cmd_pkg;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SEND   = 3'd3,
      ST_FINISH = 3'd4
   } dump_state_e;

   function automatic int dump_byte_count(input int pixel_width, input int bytes_per_pixel);
      return pixel_width * bytes_per_pixel;
   endfunction
endpackage

// File: rtl/params_pkg.sv
// Default framebuffer geometry shared by the display command blocks.
package params_pkg;
   localparam int BYTES_PER_PIXEL = 2;
   localparam int PIXEL_WIDTH     = 4;
   localparam int PIXEL_HEIGHT    = 16;
endpackage

// File: rtl/pixel_addr_countdown.sv
// Column/pixel down-counter walking a row MSB-first; holds at column 0 / pixel 0.
module pixel_addr_countdown #(
   parameter int PIXEL_WIDTH     = 4,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int COL_W           = 2,
   parameter int PIX_W           = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   output logic [COL_W-1:0] column,
   output logic [PIX_W-1:0] pixel,
   output logic             last
);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(PIXEL_WIDTH - 1);
   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(BYTES_PER_PIXEL - 1);
   localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
   localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

   logic [COL_W-1:0] col_q, col_d;
   logic [PIX_W-1:0] pix_q, pix_d;

   assign last   = (col_q == '0) && (pix_q == '0);
   assign column = col_q;
   assign pixel  = pix_q;

   always_comb begin
      col_d = col_q;
      pix_d = pix_q;
      if (load) begin
         col_d = COL_MAX;
         pix_d = PIX_MAX;
      end else if (step && !last) begin
         if (pix_q == '0) begin
            pix_d = PIX_MAX;
            col_d = col_q - COL_ONE;
         end else begin
            pix_d = pix_q - PIX_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q <= '0;
         pix_q <= '0;
      end else begin
         col_q <= col_d;
         pix_q <= pix_d;
      end
   end
endmodule

// File: rtl/control_cmd_dumprow.sv
// Streams one framebuffer row out as bytes, pixel-fastest, highest address first.
//
// state  | meaning
// IDLE   | waiting for enable; bad row pulses row_error+done
// ISSUE  | ram_read_enable high for the current address
// WAIT   | ram_data valid, captured into tx_data
// SEND   | tx_valid held until tx_ready, then address advances
// FINISH | done pulse, framebuffer port released
module control_cmd_dumprow
   import cmd_pkg::*;
#(
   parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
   parameter int PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
   parameter int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic [7:0] data_in,
   output logic [calc_pkg::num_row_address_bits(PIXEL_HEIGHT)-1:0]         row,
   output logic [calc_pkg::num_column_address_bits(PIXEL_WIDTH)-1:0]       column,
   output logic [calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
   output logic ram_access_start,
   output logic ram_read_enable,
   input  logic [7:0] ram_data,
   output logic [7:0] tx_data,
   output logic tx_valid,
   input  logic tx_ready,
   output logic done,
   output logic row_error
);
   localparam int ROW_W = calc_pkg::num_row_address_bits(PIXEL_HEIGHT);
   localparam int COL_W = calc_pkg::num_column_address_bits(PIXEL_WIDTH);
   localparam int PIX_W = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL);
   // data_in is 8 bits wide, so any taller frame accepts every value.
   localparam logic [8:0] ROW_LIMIT = (PIXEL_HEIGHT > 256) ? 9'd256 : 9'(PIXEL_HEIGHT);

   dump_state_e state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic tx_valid_q, tx_valid_d;
   logic ras_q, ras_d;
   logic rre_q, rre_d;
   logic done_q, done_d;
   logic err_q, err_d;
   logic cnt_load, cnt_step, cnt_last;
   logic row_ok;

   assign row_ok = ({1'b0, data_in} < ROW_LIMIT);

   pixel_addr_countdown #(
      .PIXEL_WIDTH     (PIXEL_WIDTH),
      .BYTES_PER_PIXEL (BYTES_PER_PIXEL),
      .COL_W           (COL_W),
      .PIX_W           (PIX_W)
   ) u_addr (
      .clk    (clk),
      .reset  (reset),
      .load   (cnt_load),
      .step   (cnt_step),
      .column (column),
      .pixel  (pixel),
      .last   (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      ras_d      = ras_q;
      rre_d      = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      cnt_load   = 1'b0;
      cnt_step   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) begin
               if (row_ok) begin
                  row_d    = ROW_W'(data_in);
                  cnt_load = 1'b1;
                  ras_d    = 1'b1;
                  rre_d    = 1'b1;
                  state_d  = ST_ISSUE;
               end else begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            tx_data_d  = ram_data;
            tx_valid_d = 1'b1;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               cnt_step   = 1'b1;
               if (cnt_last) begin
                  ras_d   = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  rre_d   = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         row_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         ras_q      <= 1'b0;
         rre_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         ras_q      <= ras_d;
         rre_q      <= rre_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign row              = row_q;
   assign tx_data          = tx_data_q;
   assign tx_valid         = tx_valid_q;
   assign ram_access_start = ras_q;
   assign ram_read_enable  = rre_q;
   assign done             = done_q;
   assign row_error        = err_q;
endmodule

// File: tb/tb_control_cmd_dumprow.sv
// Directed bench for control_cmd_dumprow with a framebuffer model and byte scoreboard.
module tb_control_cmd_dumprow;
   localparam int PW  = 4;
   localparam int BPP = 2;
   localparam int PH  = 16;

   logic clk = 1'b0;
   logic reset, enable, tx_ready;
   logic [7:0] data_in, ram_data, tx_data;
   logic [3:0] row;
   logic [1:0] column;
   logic [0:0] pixel;
   logic ram_access_start, ram_read_enable, tx_valid, done, row_error;

   logic [7:0] mem [0:PH*PW*BPP-1];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] held;
   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt, err_cnt, byte_cnt, last_cycles;
   bit tv_seen, ras_seen, rand_rdy, hold_pending, poke_finish;

   always #5 clk = ~clk;

   control_cmd_dumprow #(
      .BYTES_PER_PIXEL (BPP),
      .PIXEL_WIDTH     (PW),
      .PIXEL_HEIGHT    (PH)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .data_in          (data_in),
      .row              (row),
      .column           (column),
      .pixel            (pixel),
      .ram_access_start (ram_access_start),
      .ram_read_enable  (ram_read_enable),
      .ram_data         (ram_data),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .done             (done),
      .row_error        (row_error)
   );

   function automatic int addr(input int r, input int c, input int p);
      return r * PW * BPP + c * BPP + p;
   endfunction

   function automatic logic [7:0] pat(input int r, input int c, input int p);
      return {4'(r), 2'(c), 1'(p), 1'b1};
   endfunction

   always @(posedge clk)
      if (ram_read_enable) ram_data <= mem[addr(int'(row), int'(column), int'(pixel))];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (poke_finish && enable) begin
         enable      = 1'b0;
         poke_finish = 1'b0;
      end
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold_pending) begin
         check("hold_valid", 32'(tx_valid), 32'd1);
         check("hold_data", 32'(tx_data), 32'(held));
      end
      hold_pending = tx_valid && !tx_ready;
      held = tx_data;
      if (tx_valid && tx_ready) begin
         byte_cnt++;
         got_q.push_back(tx_data);
         check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done) begin
         done_cnt++;
         check("ras_low_at_done", 32'(ram_access_start), 32'd0);
         if (poke_finish) begin
            data_in = 8'd2;
            enable  = 1'b1;
         end
      end
      if (row_error) err_cnt++;
      if (tx_valid) tv_seen = 1'b1;
      if (ram_access_start) ras_seen = 1'b1;
   endtask

   task automatic clear_stats();
      done_cnt = 0; err_cnt = 0; byte_cnt = 0;
      tv_seen = 1'b0; ras_seen = 1'b0; hold_pending = 1'b0;
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic push_row(input int r);
      for (int c = PW - 1; c >= 0; c--)
         for (int p = BPP - 1; p >= 0; p--) exp_q.push_back(pat(r, c, p));
   endtask

   task automatic start(input logic [7:0] d);
      data_in = d;
      enable  = 1'b1;
      tick();
      enable  = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      last_cycles = 0;
      for (int i = 0; i < max_cycles && done_cnt == 0; i++) begin
         tick();
         last_cycles++;
      end
      repeat (3) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_row"}, 32'(row), 32'd0);
      check({tag, "_column"}, 32'(column), 32'd0);
      check({tag, "_pixel"}, 32'(pixel), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_strobes"}, 32'({ram_access_start, ram_read_enable, tx_valid, done, row_error}), 32'd0);
   endtask

   initial begin
      logic [7:0] spec_bytes [0:7];
      spec_bytes = '{8'h3F, 8'h3D, 8'h3B, 8'h39, 8'h37, 8'h35, 8'h33, 8'h31};
      for (int r = 0; r < PH; r++)
         for (int c = 0; c < PW; c++)
            for (int p = 0; p < BPP; p++) mem[addr(r, c, p)] = pat(r, c, p);
      reset = 1'b0; enable = 1'b0; data_in = 8'd0; tx_ready = 1'b1;
      rand_rdy = 1'b0; poke_finish = 1'b0;
      clear_stats();
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b1;
      repeat (2) tick();

      // row 3 with tx_ready held high
      clear_stats();
      for (int i = 0; i < 8; i++) exp_q.push_back(spec_bytes[i]);
      start(8'd3);
      check("accept_row", 32'(row), 32'd3);
      check("accept_column", 32'(column), 32'd3);
      check("accept_pixel", 32'(pixel), 32'd1);
      check("accept_strobes", 32'({ram_access_start, ram_read_enable}), 32'd3);
      wait_done(100);
      check("a_done", 32'(done_cnt), 32'd1);
      check("a_bytes", 32'(byte_cnt), 32'd8);
      check("a_queue_empty", 32'(exp_q.size()), 32'd0);
      check("a_no_error", 32'(err_cnt), 32'd0);
      check("a_throughput", 32'(last_cycles <= 24), 32'd1);
      check("a_idle_after", 32'({ram_access_start, tx_valid}), 32'd0);

      // row 3 with random back-pressure
      clear_stats();
      rand_rdy = 1'b1;
      push_row(3);
      start(8'd3);
      wait_done(400);
      rand_rdy = 1'b0;
      check("b_done", 32'(done_cnt), 32'd1);
      check("b_bytes", 32'(byte_cnt), 32'd8);
      check("b_queue_empty", 32'(exp_q.size()), 32'd0);

      // out-of-range row
      clear_stats();
      start(8'd16);
      wait_done(20);
      check("c_row_error", 32'(err_cnt), 32'd1);
      check("c_done", 32'(done_cnt), 32'd1);
      check("c_no_tx_valid", 32'(tv_seen), 32'd0);
      check("c_no_ras", 32'(ras_seen), 32'd0);

      // enables while busy and in the FINISH cycle are ignored
      clear_stats();
      push_row(3);
      start(8'd3);
      repeat (5) tick();
      data_in = 8'd5;
      enable  = 1'b1;
      tick();
      enable  = 1'b0;
      poke_finish = 1'b1;
      wait_done(200);
      repeat (10) tick();
      poke_finish = 1'b0;
      enable = 1'b0;
      check("d_bytes", 32'(byte_cnt), 32'd8);
      check("d_done", 32'(done_cnt), 32'd1);
      check("d_queue_empty", 32'(exp_q.size()), 32'd0);
      check("d_row_kept", 32'(row), 32'd3);
      check("d_idle_after", 32'({ram_access_start, tx_valid}), 32'd0);

      // reset mid-row, then a fresh row 7
      clear_stats();
      push_row(3);
      start(8'd3);
      for (int i = 0; i < 100 && byte_cnt < 3; i++) tick();
      check("e_three_bytes", 32'(byte_cnt), 32'd3);
      tick();
      reset = 1'b0;
      #1;
      check_all_zero("midrow_reset");
      exp_q.delete();
      hold_pending = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      clear_stats();
      push_row(7);
      start(8'd7);
      wait_done(100);
      check("e_done", 32'(done_cnt), 32'd1);
      check("e_bytes", 32'(byte_cnt), 32'd8);
      check("e_queue_empty", 32'(exp_q.size()), 32'd0);

      // loopback: dumped row 3 written back as row 9 in readrow's MSB-first order
      clear_stats();
      push_row(3);
      start(8'd3);
      wait_done(100);
      check("f_captured", 32'(got_q.size()), 32'd8);
      if (got_q.size() == 8) begin
         int idx = 0;
         for (int c = PW - 1; c >= 0; c--)
            for (int p = BPP - 1; p >= 0; p--) begin
               mem[addr(9, c, p)] = got_q[idx];
               idx++;
            end
         for (int c = 0; c < PW; c++)
            for (int p = 0; p < BPP; p++)
               check("loopback_row9", 32'(mem[addr(9, c, p)]), 32'(pat(3, c, p)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/control_cmd_dumprow.md
CONTROL_CMD_DUMPROW -- requirements
Module: control_cmd_dumprow

Interface
REQ-001 SHALL have parameter BYTES_PER_PIXEL, default params_pkg::BYTES_PER_PIXEL, bytes per pixel.
REQ-002 SHALL have parameter PIXEL_WIDTH, default params_pkg::PIXEL_WIDTH, columns per row.
REQ-003 SHALL have parameter PIXEL_HEIGHT, default params_pkg::PIXEL_HEIGHT, rows per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port enable  input  1  one-cycle strobe qualifying data_in.
REQ-007 SHALL have port data_in  input  8  row-select byte.
REQ-008 SHALL have ports row, column, pixel  output  calc_pkg::num_row_address_bits(PIXEL_HEIGHT), calc_pkg::num_column_address_bits(PIXEL_WIDTH), calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)  framebuffer read address.
REQ-009 SHALL have port ram_access_start  output  1  high while the block owns the framebuffer port.
REQ-010 SHALL have port ram_read_enable  output  1  one-cycle read strobe.
REQ-011 SHALL have port ram_data  input  8  read data, valid exactly 1 cycle after ram_read_enable.
REQ-012 SHALL have ports tx_data output 8, tx_valid output 1, tx_ready input 1  outbound byte stream; byte transfers when tx_valid & tx_ready.
REQ-013 SHALL have ports done output 1 and row_error output 1  one-cycle completion and bad-row pulses.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, SEND, FINISH.
REQ-015 IDLE: on enable, SHALL latch data_in; if data_in < PIXEL_HEIGHT, row <= data_in, column <= PIXEL_WIDTH-1, pixel <= BYTES_PER_PIXEL-1, go ISSUE; otherwise pulse row_error and done in the next cycle, emit no bytes, stay IDLE.
REQ-016 ISSUE SHALL assert ram_read_enable for exactly one cycle, then go WAIT; WAIT SHALL capture ram_data into tx_data, assert tx_valid, and go SEND.
REQ-017 SEND SHALL hold tx_valid and tx_data stable until tx_ready; on transfer it SHALL drop tx_valid in the same edge and advance the address.
REQ-018 Address advance SHALL be pixel-fastest and descending: pixel decrements; at 0 it reloads BYTES_PER_PIXEL-1 and column decrements; after column 0 / pixel 0 transfers, go FINISH. Otherwise go ISSUE.
REQ-019 Byte order SHALL equal the MSB-first order consumed by control_cmd_readrow, so a dump fed back into readrow rewrites the row unchanged.
REQ-020 Total bytes per command SHALL be exactly PIXEL_WIDTH*BYTES_PER_PIXEL; counters SHALL not wrap past 0.
REQ-021 FINISH SHALL pulse done for one cycle, deassert ram_access_start, and return to IDLE.
REQ-022 ram_access_start SHALL be high from the cycle after accepting a valid row until FINISH.
REQ-023 enable while not IDLE SHALL be ignored; an enable in the FINISH cycle SHALL be ignored.
REQ-024 tx_ready asserted while tx_valid is low SHALL have no effect.
REQ-025 Minimum throughput with tx_ready held high SHALL be one byte per 3 clocks.

Reset
REQ-026 Asserting reset (low) at any time, including mid-row, SHALL immediately force IDLE and drive row, column, pixel, tx_data = 0 and ram_access_start, ram_read_enable, tx_valid, done, row_error = 0.
REQ-027 After reset release, the first enable SHALL be accepted normally; no partial row SHALL resume.

Structure
REQ-028 The state enum SHALL live in a shared package (cmd_pkg) alongside any dump-byte-count constant; widths SHALL come from calc_pkg.
REQ-029 The column/pixel down-counter SHALL be a sub-module, pixel_addr_countdown, with load, step, and last outputs.

Verification
REQ-030 PIXEL_WIDTH=4, BYTES_PER_PIXEL=2, PIXEL_HEIGHT=16, RAM preloaded byte = {row[3:0], col[1:0], pix[0], 1'b1}; enable with data_in=3, tx_ready=1 -> 8 bytes 0x3F,0x3D,0x3B,0x39,0x37,0x35,0x33,0x31 then one done pulse.
REQ-031 Same setup, tx_ready toggled pseudo-randomly -> identical 8-byte sequence, tx_data never changes while tx_valid & !tx_ready.
REQ-032 enable with data_in=16 -> row_error and done pulse once, tx_valid never asserted, ram_access_start stays 0.
REQ-033 Second enable (data_in=5) during row 3 dump -> ignored; exactly 8 row-3 bytes output.
REQ-034 reset low after 3rd byte transfer -> all outputs 0 next sample; then enable data_in=7 -> full 8-byte row 7 dump.
REQ-035 Loopback: dump output streamed into control_cmd_readrow targeting row 9 -> RAM row 9 equals row 3 byte-for-byte.
